mul_sched: RTL and testbench
============================

# mul_sched

Shared-multiplier scheduler placed between two issue ports of the scalar pipeline and one `mul_unit` instance. It arbitrates round-robin between the ports and holds the winning operation's operands and controls stable for the unit's full fixed latency. It captures the single-cycle result pulse and returns it on a shared valid/ready response channel with port id and tag. Per-port kills cancel in-flight or pending work.

## Interface
- `XLEN`, 64: operand/result width.
- `TAG_W`, 4: requester tag width.
- `MUL_LAT`, 2: cycles from `mul_req_o` cycle to the `mul_result_i` valid cycle.

- `clk_i`  in  1  clock; all state on rising edge.
- `rstn_i`  in  1  asynchronous, active-low reset.
- `p0_valid_i` / `p1_valid_i`  in  1  request valid, per port.
- `p0_ready_o` / `p1_ready_o`  out  1  request accepted this cycle.
- `p0_func3_i` / `p1_func3_i`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
- `p0_int_32_i` / `p1_int_32_i`  in  1  W-variant (32-bit, sign-extended).
- `p0_src1_i`, `p0_src2_i`, `p1_src1_i`, `p1_src2_i`  in  XLEN  operands.
- `p0_tag_i` / `p1_tag_i`  in  TAG_W  returned unchanged.
- `kill_i`  in  2  bit n cancels port n's pending or in-flight op.
- `mul_req_o`  out  1  to multiplier `request_i`.
- `mul_kill_o`  out  1  to multiplier `kill_mul_i`.
- `mul_func3_o`  out  3  to multiplier `func3_i`.
- `mul_int_32_o`  out  1  to multiplier `int_32_i`.
- `mul_src1_o`, `mul_src2_o`  out  XLEN  to multiplier operands.
- `mul_result_i`  in  XLEN  from multiplier; nonzero only in its done cycle.
- `mul_stall_i`  in  1  from multiplier; lockstep check only.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response consumed.
- `rsp_port_o`  out  1  owning port.
- `rsp_tag_o`  out  TAG_W  owning tag.
- `rsp_result_o`  out  XLEN  result.
- `err_o`  out  1  sticky lockstep error.

## Operation
- States: IDLE, EXEC (counter `cnt` 0..MUL_LAT), RESP.
- **IDLE**
  - Eligible port: `pn_valid_i & ~kill_i[n]`.
  - If exactly one port is eligible, grant it. If both are eligible, grant the port selected by `prio_q`.
  - The granted port's `ready_o` is 1 combinationally. At most one `ready_o` is high; both are 0 outside IDLE.
  - On grant: latch func3, int_32, src1, src2, tag, and port into op registers. Set `prio_q <=` the non-granted port.
  - func3 = 1xx: go to RESP with result 0; the multiplier is never requested.
  - Otherwise: go to EXEC with `cnt` = 0.
- **EXEC**
  - `mul_src*`, `mul_func3_o`, and `mul_int_32_o` are driven from the op registers for every EXEC cycle. They are 0 in IDLE and RESP.
  - `mul_req_o` = 1 only at `cnt` = 0.
  - At `cnt` = MUL_LAT: latch `mul_result_i` into the response register and go to RESP.
- **Kill**
  - `kill_i[port_q]` in EXEC: `mul_kill_o` = 1 that cycle (combinational), next state IDLE, no response.
  - `kill_i[port_q]` in RESP: `rsp_valid_o` drops next cycle, next state IDLE.
  - Kill of the non-owning port only masks that port's eligibility.
- **RESP**
  - `rsp_valid_o` = 1; port, tag, and result are held stable until `rsp_ready_i`.
  - On handshake, next state IDLE. No new request is accepted in the handshake cycle.
- **Lockstep check:** `mul_stall_i` must be 1 for `cnt` < MUL_LAT and 0 at `cnt` = MUL_LAT. Any mismatch sets `err_o` until reset.

## Timing
- Reset: state IDLE and `prio_q` = 0 (port 0 favoured).
  - All outputs 0: `ready_o`, `mul_*`, `rsp_*`, `err_o`.
  - Op and response registers cleared.
- Request accepted at cycle T:
  - `mul_req_o` at T+1.
  - Result captured at the end of cycle T+1+MUL_LAT (T+3 with the default).
  - `rsp_valid_o` from T+4.
- Minimum issue period is 5 cycles at MUL_LAT = 2 with `rsp_ready_i` held high.
- Illegal func3: `rsp_valid_o` at T+1.
- Reset asserted mid-operation: immediate return to reset values; the in-flight op is lost and no response is produced.
- Kill at `cnt` = MUL_LAT: takes priority over capture.
- Kill and `rsp_ready_i` in the same RESP cycle: treated as a kill (identical outcome, no second response).

## Test plan
- **Single MUL:** port 0, func3 000, int_32 0, src1 3, src2 −5, tag 0x7, accepted at T.
  - `mul_req_o` only at T+1.
  - `rsp_valid_o` at T+4 with result 0xFFFFFFFFFFFFFFF1, port 0, tag 0x7.
- **Contention:** both ports valid continuously after reset.
  - Grants alternate p0, p1, p0, p1.
  - Responses in that order.
  - Never both `ready_o` high.
- **Kill:** `kill_i[0]` at T+2 of a port-0 MULHU.
  - `mul_kill_o` = 1 at T+2.
  - No response.
  - A pending port-1 request is accepted at T+3.
- **Backpressure:** `rsp_ready_i` = 0 for 3 cycles in RESP.
  - Response fields held stable.
  - Both `ready_o` low.
  - Next accept in the cycle after the handshake.
- **Illegal op:** func3 100, tag 0x3.
  - Response result 0 at T+1.
  - `mul_req_o` never asserted.
- **Lockstep error and reset:** force `mul_stall_i` = 0 at `cnt` = 0 → `err_o` latched high. Then assert `rstn_i` low mid-EXEC → all outputs 0 and `err_o` cleared.

Source files
------------

// File: rtl/mul_sched_if.sv
// +----------------------------------------------------------------------+
// | mul_sched_if : issue ports, multiplier link and response channel     |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

interface mul_sched_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 4
);
  logic             p0_valid_i;
  logic             p1_valid_i;
  logic             p0_ready_o;
  logic             p1_ready_o;
  logic [2:0]       p0_func3_i;
  logic [2:0]       p1_func3_i;
  logic             p0_int_32_i;
  logic             p1_int_32_i;
  logic [XLEN-1:0]  p0_src1_i;
  logic [XLEN-1:0]  p0_src2_i;
  logic [XLEN-1:0]  p1_src1_i;
  logic [XLEN-1:0]  p1_src2_i;
  logic [TAG_W-1:0] p0_tag_i;
  logic [TAG_W-1:0] p1_tag_i;
  logic [1:0]       kill_i;

  logic             mul_req_o;
  logic             mul_kill_o;
  logic [2:0]       mul_func3_o;
  logic             mul_int_32_o;
  logic [XLEN-1:0]  mul_src1_o;
  logic [XLEN-1:0]  mul_src2_o;
  logic [XLEN-1:0]  mul_result_i;
  logic             mul_stall_i;

  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic             rsp_port_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic [XLEN-1:0]  rsp_result_o;
  logic             err_o;

  modport slave (
    input  p0_valid_i, p1_valid_i, p0_func3_i, p1_func3_i, p0_int_32_i, p1_int_32_i,
           p0_src1_i, p0_src2_i, p1_src1_i, p1_src2_i, p0_tag_i, p1_tag_i, kill_i,
           mul_result_i, mul_stall_i, rsp_ready_i,
    output p0_ready_o, p1_ready_o, mul_req_o, mul_kill_o, mul_func3_o, mul_int_32_o,
           mul_src1_o, mul_src2_o, rsp_valid_o, rsp_port_o, rsp_tag_o, rsp_result_o, err_o
  );

  modport master (
    output p0_valid_i, p1_valid_i, p0_func3_i, p1_func3_i, p0_int_32_i, p1_int_32_i,
           p0_src1_i, p0_src2_i, p1_src1_i, p1_src2_i, p0_tag_i, p1_tag_i, kill_i,
           mul_result_i, mul_stall_i, rsp_ready_i,
    input  p0_ready_o, p1_ready_o, mul_req_o, mul_kill_o, mul_func3_o, mul_int_32_o,
           mul_src1_o, mul_src2_o, rsp_valid_o, rsp_port_o, rsp_tag_o, rsp_result_o, err_o
  );
endinterface

`default_nettype wire

// File: rtl/mul_sched.sv
// +----------------------------------------------------------------------+
// | mul_sched : round-robin scheduler sharing one fixed-latency multiplier|
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module mul_sched #(
  parameter int XLEN    = 64,
  parameter int TAG_W   = 4,
  parameter int MUL_LAT = 2
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  mul_sched_if.slave bus
);
  localparam int               CNT_W   = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MUL_LAT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prio_q, prio_d;
  logic [2:0]       func3_q, func3_d;
  logic             int_32_q, int_32_d;
  logic [XLEN-1:0]  src1_q, src1_d;
  logic [XLEN-1:0]  src2_q, src2_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             port_q, port_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             err_q, err_d;

  logic elig0, elig1, grant0, grant1, kill_own, stall_exp, in_exec, in_resp;
  logic [2:0] sel_func3;

  always_comb begin
    in_exec   = (state_q == ST_EXEC);
    in_resp   = (state_q == ST_RESP);
    elig0     = bus.p0_valid_i & ~bus.kill_i[0];
    elig1     = bus.p1_valid_i & ~bus.kill_i[1];
    // prio_q names the port that wins a tie
    grant0    = (state_q == ST_IDLE) & elig0 & (~elig1 | ~prio_q);
    grant1    = (state_q == ST_IDLE) & elig1 & (~elig0 |  prio_q);
    kill_own  = bus.kill_i[port_q];
    stall_exp = (cnt_q != CNT_MAX);
    sel_func3 = grant1 ? bus.p1_func3_i : bus.p0_func3_i;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prio_d   = prio_q;
    func3_d  = func3_q;
    int_32_d = int_32_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    tag_d    = tag_q;
    port_d   = port_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant0 | grant1) begin
          port_d   = grant1;
          prio_d   = ~grant1;
          func3_d  = sel_func3;
          int_32_d = grant1 ? bus.p1_int_32_i : bus.p0_int_32_i;
          src1_d   = grant1 ? bus.p1_src1_i   : bus.p0_src1_i;
          src2_d   = grant1 ? bus.p1_src2_i   : bus.p0_src2_i;
          tag_d    = grant1 ? bus.p1_tag_i    : bus.p0_tag_i;
          cnt_d    = '0;
          // Unsupported encodings answer immediately with a zero result
          if (sel_func3[2]) begin
            result_d = '0;
            state_d  = ST_RESP;
          end else begin
            state_d  = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (bus.mul_stall_i != stall_exp) err_d = 1'b1;
        if (kill_own) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          result_d = bus.mul_result_i;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (kill_own | bus.rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.p0_ready_o   = grant0;
    bus.p1_ready_o   = grant1;
    bus.mul_req_o    = in_exec & (cnt_q == '0);
    bus.mul_kill_o   = in_exec & kill_own;
    bus.mul_func3_o  = in_exec ? func3_q  : 3'b000;
    bus.mul_int_32_o = in_exec & int_32_q;
    bus.mul_src1_o   = in_exec ? src1_q   : '0;
    bus.mul_src2_o   = in_exec ? src2_q   : '0;
    bus.rsp_valid_o  = in_resp;
    bus.rsp_port_o   = in_resp & port_q;
    bus.rsp_tag_o    = in_resp ? tag_q    : '0;
    bus.rsp_result_o = in_resp ? result_q : '0;
    bus.err_o        = err_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      prio_q   <= 1'b0;
      func3_q  <= 3'b000;
      int_32_q <= 1'b0;
      src1_q   <= '0;
      src2_q   <= '0;
      tag_q    <= '0;
      port_q   <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prio_q   <= prio_d;
      func3_q  <= func3_d;
      int_32_q <= int_32_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      tag_q    <= tag_d;
      port_q   <= port_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_mul_sched.sv
// +----------------------------------------------------------------------+
// | tb_mul_sched : directed self-checking bench for mul_sched            |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_mul_sched;
  localparam int XLEN    = 64;
  localparam int TAG_W   = 4;
  localparam int MUL_LAT = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mul_sched_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  mul_sched #(.XLEN(XLEN), .TAG_W(TAG_W), .MUL_LAT(MUL_LAT)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  // Behavioural multiplier: stall while busy, one-cycle result pulse at done
  int              m_cnt;
  logic [XLEN-1:0] m_prod;
  logic            force_stall_low = 1'b0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_cnt  <= 0;
      m_prod <= '0;
    end else if (bus.mul_kill_o) begin
      m_cnt  <= 0;
    end else if (bus.mul_req_o) begin
      m_cnt  <= 1;
      m_prod <= bus.mul_src1_o * bus.mul_src2_o;
    end else if (m_cnt == MUL_LAT) begin
      m_cnt  <= 0;
    end else if (m_cnt != 0) begin
      m_cnt  <= m_cnt + 1;
    end
  end

  assign bus.mul_stall_i  = force_stall_low ? 1'b0 : (bus.mul_req_o | (m_cnt != 0 && m_cnt < MUL_LAT));
  assign bus.mul_result_i = (m_cnt == MUL_LAT) ? m_prod : '0;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    bus.p0_valid_i = 1'b0; bus.p1_valid_i = 1'b0;
    bus.p0_func3_i = 3'b000; bus.p1_func3_i = 3'b000;
    bus.p0_int_32_i = 1'b0; bus.p1_int_32_i = 1'b0;
    bus.p0_src1_i = '0; bus.p0_src2_i = '0; bus.p1_src1_i = '0; bus.p1_src2_i = '0;
    bus.p0_tag_i = '0; bus.p1_tag_i = '0;
    bus.kill_i = 2'b00; bus.rsp_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cyc(); cyc();
    rstn = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    clear_inputs();
    cyc();
    rstn = 1'b0;
    #1;
    checks++; if (bus.p0_ready_o !== 1'b0) begin failures++; $display("FAIL reset_p0_ready got=%b want=0", bus.p0_ready_o); end
    checks++; if (bus.p1_ready_o !== 1'b0) begin failures++; $display("FAIL reset_p1_ready got=%b want=0", bus.p1_ready_o); end
    checks++; if (bus.mul_req_o !== 1'b0) begin failures++; $display("FAIL reset_mul_req got=%b want=0", bus.mul_req_o); end
    checks++; if (bus.mul_kill_o !== 1'b0) begin failures++; $display("FAIL reset_mul_kill got=%b want=0", bus.mul_kill_o); end
    checks++; if (bus.mul_src1_o !== 64'd0) begin failures++; $display("FAIL reset_mul_src1 got=%h want=0", bus.mul_src1_o); end
    checks++; if (bus.rsp_valid_o !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid_o); end
    checks++; if (bus.rsp_result_o !== 64'd0) begin failures++; $display("FAIL reset_rsp_result got=%h want=0", bus.rsp_result_o); end
    checks++; if (bus.err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", bus.err_o); end
    cyc();
    rstn = 1'b1;
    cyc();
  endtask

  task automatic test_single_mul();
    bus.p0_valid_i = 1'b1; bus.p0_func3_i = 3'b000; bus.p0_int_32_i = 1'b0;
    bus.p0_src1_i = 64'd3; bus.p0_src2_i = 64'hFFFF_FFFF_FFFF_FFFB; bus.p0_tag_i = 4'h7;
    #1;
    checks++; if (bus.p0_ready_o !== 1'b1) begin failures++; $display("FAIL single_p0_ready got=%b want=1", bus.p0_ready_o); end
    checks++; if (bus.p1_ready_o !== 1'b0) begin failures++; $display("FAIL single_p1_ready got=%b want=0", bus.p1_ready_o); end
    checks++; if (bus.mul_req_o !== 1'b0) begin failures++; $display("FAIL single_req_T got=%b want=0", bus.mul_req_o); end
    cyc(); bus.p0_valid_i = 1'b0; #1;
    checks++; if (bus.mul_req_o !== 1'b1) begin failures++; $display("FAIL single_req_T1 got=%b want=1", bus.mul_req_o); end
    checks++; if (bus.mul_src2_o !== 64'hFFFF_FFFF_FFFF_FFFB) begin failures++; $display("FAIL single_src2 got=%h want=fffffffffffffffb", bus.mul_src2_o); end
    cyc(); #1;
    checks++; if (bus.mul_req_o !== 1'b0) begin failures++; $display("FAIL single_req_T2 got=%b want=0", bus.mul_req_o); end
    checks++; if (bus.mul_src1_o !== 64'd3) begin failures++; $display("FAIL single_src1_hold got=%h want=3", bus.mul_src1_o); end
    cyc(); #1;
    checks++; if (bus.rsp_valid_o !== 1'b0) begin failures++; $display("FAIL single_rsp_early got=%b want=0", bus.rsp_valid_o); end
    cyc(); #1;
    checks++; if (bus.rsp_valid_o !== 1'b1) begin failures++; $display("FAIL single_rsp_valid got=%b want=1", bus.rsp_valid_o); end
    checks++; if (bus.rsp_result_o !== 64'hFFFF_FFFF_FFFF_FFF1) begin failures++; $display("FAIL single_result got=%h want=fffffffffffffff1", bus.rsp_result_o); end
    checks++; if (bus.rsp_port_o !== 1'b0) begin failures++; $display("FAIL single_port got=%b want=0", bus.rsp_port_o); end
    checks++; if (bus.rsp_tag_o !== 4'h7) begin failures++; $display("FAIL single_tag got=%h want=7", bus.rsp_tag_o); end
    checks++; if (bus.mul_src1_o !== 64'd0) begin failures++; $display("FAIL single_src1_resp got=%h want=0", bus.mul_src1_o); end
    bus.rsp_ready_i = 1'b1;
    cyc(); bus.rsp_ready_i = 1'b0; #1;
    checks++; if (bus.rsp_valid_o !== 1'b0) begin failures++; $display("FAIL single_rsp_done got=%b want=0", bus.rsp_valid_o); end
  endtask

  task automatic test_contention();
    int   g_n = 0;
    int   r_n = 0;
    logic g_port [4];
    logic r_port [4];
    logic [XLEN-1:0] r_res [4];
    logic exp_port [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [XLEN-1:0] exp_res [4] = '{64'd6, 64'd20, 64'd6, 64'd20};
    do_reset();
    bus.p0_valid_i = 1'b1; bus.p0_src1_i = 64'd2; bus.p0_src2_i = 64'd3; bus.p0_tag_i = 4'h1;
    bus.p1_valid_i = 1'b1; bus.p1_src1_i = 64'd4; bus.p1_src2_i = 64'd5; bus.p1_tag_i = 4'h2;
    bus.rsp_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++; if (bus.p0_ready_o & bus.p1_ready_o) begin failures++; $display("FAIL cont_both_ready cycle=%0d got=11 want=not both", i); end
      if (bus.p0_ready_o && g_n < 4) begin g_port[g_n] = 1'b0; g_n++; end
      else if (bus.p1_ready_o && g_n < 4) begin g_port[g_n] = 1'b1; g_n++; end
      if (bus.rsp_valid_o && r_n < 4) begin r_port[r_n] = bus.rsp_port_o; r_res[r_n] = bus.rsp_result_o; r_n++; end
      cyc();
    end
    bus.p0_valid_i = 1'b0; bus.p1_valid_i = 1'b0;
    checks++; if (g_n != 4) begin failures++; $display("FAIL cont_grant_count got=%0d want=4", g_n); end
    checks++; if (r_n != 4) begin failures++; $display("FAIL cont_rsp_count got=%0d want=4", r_n); end
    for (int k = 0; k < 4; k++) begin
      if (k < g_n) begin
        checks++; if (g_port[k] !== exp_port[k]) begin failures++; $display("FAIL cont_grant[%0d] got=%b want=%b", k, g_port[k], exp_port[k]); end
      end
      if (k < r_n) begin
        checks++; if (r_port[k] !== exp_port[k]) begin failures++; $display("FAIL cont_rsp_port[%0d] got=%b want=%b", k, r_port[k], exp_port[k]); end
        checks++; if (r_res[k] !== exp_res[k]) begin failures++; $display("FAIL cont_rsp_res[%0d] got=%0d want=%0d", k, r_res[k], exp_res[k]); end
      end
    end
  endtask

  task automatic test_kill();
    bus.rsp_ready_i = 1'b1;
    bus.p0_valid_i = 1'b1; bus.p0_func3_i = 3'b011; bus.p0_src1_i = 64'd7; bus.p0_src2_i = 64'd9; bus.p0_tag_i = 4'h5;
    #1;
    checks++; if (bus.p0_ready_o !== 1'b1) begin failures++; $display("FAIL kill_p0_ready got=%b want=1", bus.p0_ready_o); end
    cyc();
    bus.p0_valid_i = 1'b0;
    bus.p1_valid_i = 1'b1; bus.p1_func3_i = 3'b000; bus.p1_src1_i = 64'd7; bus.p1_src2_i = 64'd6; bus.p1_tag_i = 4'h9;
    #1;
    checks++; if (bus.p1_ready_o !== 1'b0) begin failures++; $display("FAIL kill_p1_busy got=%b want=0", bus.p1_ready_o); end
    checks++; if (bus.mul_func3_o !== 3'b011) begin failures++; $display("FAIL kill_func3 got=%b want=011", bus.mul_func3_o); end
    cyc(); bus.kill_i = 2'b01; #1;
    checks++; if (bus.mul_kill_o !== 1'b1) begin failures++; $display("FAIL kill_mul_kill got=%b want=1", bus.mul_kill_o); end
    cyc(); bus.kill_i = 2'b00; #1;
    checks++; if (bus.mul_kill_o !== 1'b0) begin failures++; $display("FAIL kill_mul_kill_clr got=%b want=0", bus.mul_kill_o); end
    checks++; if (bus.rsp_valid_o !== 1'b0) begin failures++; $display("FAIL kill_no_rsp got=%b want=0", bus.rsp_valid_o); end
    checks++; if (bus.p1_ready_o !== 1'b1) begin failures++; $display("FAIL kill_p1_accept got=%b want=1", bus.p1_ready_o); end
    cyc(); bus.p1_valid_i = 1'b0;
    cyc(); cyc(); cyc(); #1;
    checks++; if (bus.rsp_valid_o !== 1'b1) begin failures++; $display("FAIL kill_p1_rsp got=%b want=1", bus.rsp_valid_o); end
    checks++; if (bus.rsp_port_o !== 1'b1) begin failures++; $display("FAIL kill_p1_port got=%b want=1", bus.rsp_port_o); end
    checks++; if (bus.rsp_tag_o !== 4'h9) begin failures++; $display("FAIL kill_p1_tag got=%h want=9", bus.rsp_tag_o); end
    checks++; if (bus.rsp_result_o !== 64'd42) begin failures++; $display("FAIL kill_p1_result got=%0d want=42", bus.rsp_result_o); end
    cyc(); #1;
    checks++; if (bus.rsp_valid_o !== 1'b0) begin failures++; $display("FAIL kill_p1_done got=%b want=0", bus.rsp_valid_o); end
  endtask

  task automatic test_backpressure();
    bus.rsp_ready_i = 1'b0;
    bus.p0_valid_i = 1'b1; bus.p0_func3_i = 3'b000; bus.p0_src1_i = 64'd10; bus.p0_src2_i = 64'd10; bus.p0_tag_i = 4'hA;
    #1;
    checks++; if (bus.p0_ready_o !== 1'b1) begin failures++; $display("FAIL bp_p0_ready got=%b want=1", bus.p0_ready_o); end
    cyc();
    bus.p0_valid_i = 1'b0;
    bus.p1_valid_i = 1'b1; bus.p1_func3_i = 3'b000; bus.p1_src1_i = 64'd1; bus.p1_src2_i = 64'd1; bus.p1_tag_i = 4'hB;
    cyc(); cyc(); cyc();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.rsp_valid_o !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b want=1", i, bus.rsp_valid_o); end
      checks++; if (bus.rsp_result_o !== 64'd100) begin failures++; $display("FAIL bp_result[%0d] got=%0d want=100", i, bus.rsp_result_o); end
      checks++; if (bus.rsp_tag_o !== 4'hA || bus.rsp_port_o !== 1'b0) begin failures++; $display("FAIL bp_owner[%0d] got=%h/%b want=a/0", i, bus.rsp_tag_o, bus.rsp_port_o); end
      checks++; if (bus.p0_ready_o | bus.p1_ready_o) begin failures++; $display("FAIL bp_ready[%0d] got=%b%b want=00", i, bus.p0_ready_o, bus.p1_ready_o); end
      cyc();
    end
    bus.rsp_ready_i = 1'b1; #1;
    checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_tag_o !== 4'hA) begin failures++; $display("FAIL bp_handshake got=%b/%h want=1/a", bus.rsp_valid_o, bus.rsp_tag_o); end
    checks++; if (bus.p1_ready_o !== 1'b0) begin failures++; $display("FAIL bp_no_accept_hs got=%b want=0", bus.p1_ready_o); end
    cyc(); #1;
    checks++; if (bus.p1_ready_o !== 1'b1) begin failures++; $display("FAIL bp_next_accept got=%b want=1", bus.p1_ready_o); end
    checks++; if (bus.rsp_valid_o !== 1'b0) begin failures++; $display("FAIL bp_rsp_cleared got=%b want=0", bus.rsp_valid_o); end
    cyc(); bus.p1_valid_i = 1'b0;
    cyc(); cyc(); cyc(); #1;
    checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_tag_o !== 4'hB || bus.rsp_result_o !== 64'd1) begin
      failures++; $display("FAIL bp_p1_rsp got=%b/%h/%0d want=1/b/1", bus.rsp_valid_o, bus.rsp_tag_o, bus.rsp_result_o);
    end
    cyc();
    bus.rsp_ready_i = 1'b0;
  endtask

  task automatic test_illegal();
    bus.rsp_ready_i = 1'b0;
    bus.p0_valid_i = 1'b1; bus.p0_func3_i = 3'b100; bus.p0_src1_i = 64'd5; bus.p0_src2_i = 64'd5; bus.p0_tag_i = 4'h3;
    #1;
    checks++; if (bus.p0_ready_o !== 1'b1) begin failures++; $display("FAIL ill_p0_ready got=%b want=1", bus.p0_ready_o); end
    cyc(); bus.p0_valid_i = 1'b0; bus.p0_func3_i = 3'b000; #1;
    checks++; if (bus.rsp_valid_o !== 1'b1) begin failures++; $display("FAIL ill_rsp_valid got=%b want=1", bus.rsp_valid_o); end
    checks++; if (bus.rsp_result_o !== 64'd0) begin failures++; $display("FAIL ill_result got=%h want=0", bus.rsp_result_o); end
    checks++; if (bus.rsp_tag_o !== 4'h3) begin failures++; $display("FAIL ill_tag got=%h want=3", bus.rsp_tag_o); end
    checks++; if (bus.mul_req_o !== 1'b0) begin failures++; $display("FAIL ill_req_T1 got=%b want=0", bus.mul_req_o); end
    bus.rsp_ready_i = 1'b1;
    cyc(); #1;
    checks++; if (bus.rsp_valid_o !== 1'b0 || bus.mul_req_o !== 1'b0) begin failures++; $display("FAIL ill_done got=%b/%b want=0/0", bus.rsp_valid_o, bus.mul_req_o); end
    bus.rsp_ready_i = 1'b0;
  endtask

  task automatic test_lockstep_reset();
    logic seen_bad = 1'b0;
    #1;
    checks++; if (bus.err_o !== 1'b0) begin failures++; $display("FAIL lock_err_pre got=%b want=0", bus.err_o); end
    force_stall_low = 1'b1;
    bus.p0_valid_i = 1'b1; bus.p0_func3_i = 3'b000; bus.p0_src1_i = 64'd3; bus.p0_src2_i = 64'd4; bus.p0_tag_i = 4'h1;
    cyc(); bus.p0_valid_i = 1'b0; #1;
    checks++; if (bus.mul_req_o !== 1'b1) begin failures++; $display("FAIL lock_req got=%b want=1", bus.mul_req_o); end
    cyc(); force_stall_low = 1'b0; #1;
    checks++; if (bus.err_o !== 1'b1) begin failures++; $display("FAIL lock_err_set got=%b want=1", bus.err_o); end
    checks++; if (bus.mul_src1_o !== 64'd3) begin failures++; $display("FAIL lock_src1_exec got=%h want=3", bus.mul_src1_o); end
    rstn = 1'b0; #1;
    checks++; if (bus.err_o !== 1'b0) begin failures++; $display("FAIL lock_err_rst got=%b want=0", bus.err_o); end
    checks++; if (bus.mul_src1_o !== 64'd0 || bus.mul_req_o !== 1'b0) begin failures++; $display("FAIL lock_mul_rst got=%h/%b want=0/0", bus.mul_src1_o, bus.mul_req_o); end
    checks++; if (bus.rsp_valid_o !== 1'b0 || bus.p0_ready_o !== 1'b0) begin failures++; $display("FAIL lock_io_rst got=%b/%b want=0/0", bus.rsp_valid_o, bus.p0_ready_o); end
    cyc(); rstn = 1'b1;
    bus.rsp_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (bus.rsp_valid_o !== 1'b0 || bus.err_o !== 1'b0) seen_bad = 1'b1;
      cyc();
    end
    checks++; if (seen_bad) begin failures++; $display("FAIL lock_post_reset got=rsp_or_err want=quiet"); end
    bus.rsp_ready_i = 1'b0;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_mul();
    test_contention();
    test_kill();
    test_backpressure();
    test_illegal();
    test_lockstep_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

`default_nettype wire
